// File: rtl/run_encoder_mc.sv
// run_encoder_mc: JPEG run-length encoder for quantised 8x8 blocks in zig-zag order.
// Per-component DC prediction and restart are built only when RUN_ENCODER_DC_PRED_EN is defined.
module run_encoder_mc #(
   parameter int COEF_W   = 11,
   parameter int NUM_COMP = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [COEF_W-1:0] i_in,
   input  logic [1:0]        i_comp,
   input  logic              i_ena_in,
   output logic              o_rdy_out,
   input  logic              i_restart,
   output logic              o_ena_out,
   input  logic              i_rdy_in,
   output logic [COEF_W:0]   o_out,
   output logic [3:0]        o_size,
   output logic [3:0]        o_run,
   output logic              o_dc,
   output logic [1:0]        o_out_comp,
   output logic              o_done
);
   localparam int         OW = COEF_W + 1;
   localparam logic [2:0] NC = 3'(NUM_COMP);

   // Negative values are carried as v-1 so the Huffman stage can emit the low bits directly.
   function automatic logic [OW-1:0] amp_f(input logic [OW-1:0] v);
      amp_f = v[OW-1] ? (v - {{(OW-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [3:0] size_f(input logic [OW-1:0] v);
      logic [OW-1:0] mag;
      mag    = v[OW-1] ? (~v + {{(OW-1){1'b0}}, 1'b1}) : v;
      size_f = 4'd0;
      for (int b = 0; b < OW; b++) begin
         if (mag[b]) begin
            size_f = 4'(b + 1);
         end
      end
   endfunction

   logic [5:0]    r_idx;
   logic [5:0]    r_z;
   logic [1:0]    r_zrl;
   logic          r_hold_vld;
   logic [OW-1:0] r_hold_amp;
   logic [3:0]    r_hold_size;
   logic [3:0]    r_hold_run;
   logic          r_hold_last;
   logic          r_ena_out;
   logic [OW-1:0] r_out;
   logic [3:0]    r_size;
   logic [3:0]    r_run;
   logic          r_dc;
   logic [1:0]    r_out_comp;
   logic [1:0]    r_cur_comp;
   logic          r_last;
   logic          r_done;

   logic          w_pending;
   logic          w_out_free;
   logic          w_rdy;
   logic          w_xfer;
   logic          w_restart_ok;
   logic          w_nz;
   logic          w_idx0;
   logic          w_idx63;
   logic [1:0]    w_comp_eff;
   logic [OW-1:0] w_in_ext;
   logic [OW-1:0] w_dc_val;
   logic [OW-1:0] w_in_amp;
   logic [OW-1:0] w_dc_amp;
   logic [3:0]    w_in_size;
   logic [3:0]    w_dc_size;

   assign w_pending    = (r_zrl != 2'd0) || r_hold_vld;
   assign w_out_free   = !r_ena_out || i_rdy_in;
   assign w_rdy        = w_out_free && !w_pending;
   assign w_xfer       = i_ena_in && w_rdy;
   assign w_idx0       = (r_idx == 6'd0);
   assign w_idx63      = (r_idx == 6'd63);
   assign w_nz         = (i_in != {COEF_W{1'b0}});
   assign w_comp_eff   = ({1'b0, i_comp} < NC) ? i_comp : 2'd0;
   assign w_restart_ok = i_restart && w_idx0 && !r_ena_out && !w_pending;
   assign w_in_ext     = {i_in[COEF_W-1], i_in};
   assign w_in_amp     = amp_f(w_in_ext);
   assign w_in_size    = size_f(w_in_ext);
   assign w_dc_amp     = amp_f(w_dc_val);
   assign w_dc_size    = size_f(w_dc_val);

`ifdef RUN_ENCODER_DC_PRED_EN
   logic [COEF_W-1:0] r_pred [4];
   logic [OW-1:0]     w_pred_ext;

   // An honoured restart zeroes the predictor before this block's DC is differenced.
   assign w_pred_ext = w_restart_ok ? {OW{1'b0}}
                                    : {r_pred[w_comp_eff][COEF_W-1], r_pred[w_comp_eff]};
   assign w_dc_val   = w_in_ext - w_pred_ext;

   // Per-component DC predictor bank
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < 4; k++) begin
            r_pred[k] <= {COEF_W{1'b0}};
         end
      end else begin
         if (w_restart_ok) begin
            for (int k = 0; k < 4; k++) begin
               r_pred[k] <= {COEF_W{1'b0}};
            end
         end
         if (w_xfer && w_idx0) begin
            r_pred[w_comp_eff] <= i_in;
         end
      end
   end
`else
   logic w_unused_restart;
   assign w_unused_restart = w_restart_ok;
   assign w_dc_val         = w_in_ext;
`endif

   // Block sequencing, pending ZRL/held-coefficient queue and the single output register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx       <= 6'd0;
         r_z         <= 6'd0;
         r_zrl       <= 2'd0;
         r_hold_vld  <= 1'b0;
         r_hold_amp  <= {OW{1'b0}};
         r_hold_size <= 4'd0;
         r_hold_run  <= 4'd0;
         r_hold_last <= 1'b0;
         r_ena_out   <= 1'b0;
         r_out       <= {OW{1'b0}};
         r_size      <= 4'd0;
         r_run       <= 4'd0;
         r_dc        <= 1'b0;
         r_out_comp  <= 2'd0;
         r_cur_comp  <= 2'd0;
         r_last      <= 1'b0;
         r_done      <= 1'b1;
      end else begin
         if (w_xfer) begin
            r_idx <= r_idx + 6'd1;
            if (w_idx0) begin
               r_ena_out  <= 1'b1;
               r_out      <= w_dc_amp;
               r_size     <= w_dc_size;
               r_run      <= 4'd0;
               r_dc       <= 1'b1;
               r_out_comp <= w_comp_eff;
               r_cur_comp <= w_comp_eff;
               r_last     <= 1'b0;
               r_z        <= 6'd0;
            end else if (!w_nz) begin
               // Zeros emit nothing, except the EOB closing a block that ends in zeros.
               r_z        <= r_z + 6'd1;
               r_ena_out  <= w_idx63;
               r_out      <= {OW{1'b0}};
               r_size     <= 4'd0;
               r_run      <= 4'd0;
               r_dc       <= 1'b0;
               r_out_comp <= r_cur_comp;
               r_last     <= w_idx63;
            end else if (r_z[5:4] == 2'd0) begin
               r_ena_out  <= 1'b1;
               r_out      <= w_in_amp;
               r_size     <= w_in_size;
               r_run      <= r_z[3:0];
               r_dc       <= 1'b0;
               r_out_comp <= r_cur_comp;
               r_last     <= w_idx63;
               r_z        <= 6'd0;
            end else begin
               r_ena_out   <= 1'b1;
               r_out       <= {OW{1'b0}};
               r_size      <= 4'd0;
               r_run       <= 4'd15;
               r_dc        <= 1'b0;
               r_out_comp  <= r_cur_comp;
               r_last      <= 1'b0;
               r_zrl       <= r_z[5:4] - 2'd1;
               r_hold_vld  <= 1'b1;
               r_hold_amp  <= w_in_amp;
               r_hold_size <= w_in_size;
               r_hold_run  <= r_z[3:0];
               r_hold_last <= w_idx63;
               r_z         <= 6'd0;
            end
         end else if (w_out_free) begin
            if (r_zrl != 2'd0) begin
               r_ena_out  <= 1'b1;
               r_out      <= {OW{1'b0}};
               r_size     <= 4'd0;
               r_run      <= 4'd15;
               r_dc       <= 1'b0;
               r_out_comp <= r_cur_comp;
               r_last     <= 1'b0;
               r_zrl      <= r_zrl - 2'd1;
            end else if (r_hold_vld) begin
               r_ena_out  <= 1'b1;
               r_out      <= r_hold_amp;
               r_size     <= r_hold_size;
               r_run      <= r_hold_run;
               r_dc       <= 1'b0;
               r_out_comp <= r_cur_comp;
               r_last     <= r_hold_last;
               r_hold_vld <= 1'b0;
            end else begin
               r_ena_out <= 1'b0;
            end
         end else begin
            r_ena_out <= r_ena_out;
         end

         if (w_xfer && w_idx0) begin
            r_done <= 1'b0;
         end else if (r_ena_out && i_rdy_in && r_last) begin
            r_done <= 1'b1;
         end else begin
            r_done <= r_done;
         end
      end
   end

   assign o_rdy_out  = w_rdy;
   assign o_ena_out  = r_ena_out;
   assign o_out      = r_out;
   assign o_size     = r_size;
   assign o_run      = r_run;
   assign o_dc       = r_dc;
   assign o_out_comp = r_out_comp;
   assign o_done     = r_done;

endmodule

// File: doc/run_encoder_mc.md
# run_encoder_mc

Parametrised multi-component JPEG run-length encoder. It accepts quantised coefficients of 8x8 blocks in zig-zag order, one per handshake. For each block it emits one DC-difference symbol, then AC (run, size, amplitude) symbols, including ZRL (15,0) and EOB (0,0). A per-component DC predictor and output backpressure are provided. It sits between the quantiser and the Huffman coder.

## Interface
- COEF_W, 11, signed coefficient width; legal 8..14
- NUM_COMP, 3, number of components, each with its own DC predictor; legal 1..4
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in  in  COEF_W  signed coefficient
- comp  in  2  component of the block; sampled with coefficient index 0
- ena_in  in  1  `in` valid; transfer on `ena_in && rdy_out`
- rdy_out  out  1  encoder can accept a coefficient
- restart  in  1  clear all DC predictors; honoured only when the block index is 0 and no output is pending
- ena_out  out  1  symbol valid; transfer on `ena_out && rdy_in`
- rdy_in  in  1  downstream ready
- out  out  COEF_W+1  amplitude: v if v≥0, v-1 if v<0 (two's-complement, COEF_W+1 wide); 0 for ZRL and EOB
- size  out  4  bit length of |v|, 0 when v=0
- run  out  4  preceding zero count (AC only; 0 for DC)
- dc  out  1  symbol is a DC difference
- out_comp  out  2  component of the current block
- done  out  1  encoder idle between blocks

## Operation
- Block index counter 0..63 advances on each input transfer and wraps 63→0.
- Index 0, DC:
  - diff = in − pred[comp], computed at COEF_W+1 bits.
  - pred[comp] ← in.
  - Emit one symbol with dc=1, run=0.
  - A `comp` value ≥ NUM_COMP maps to component 0.
- Index 1..63, AC, using zero counter z (0..63):
  - Zero coefficient: z++; nothing is emitted, except at index 63 (see EOB).
  - Nonzero coefficient: emit floor(z/16) ZRL symbols (run=15, size=0), then (run=z mod 16, size, out); set z ← 0.
  - While ZRLs are pending the coefficient is held internally.
- EOB: when the index-63 coefficient is zero, emit one (0,0) after any pending work, with no ZRLs. A nonzero coefficient at index 63 produces no EOB.
- `done`:
  - Set to 1 by reset.
  - Cleared on the index-0 transfer.
  - Set the cycle after the handshake of the block's final symbol.
- `restart` accepted together with an index-0 transfer: clearing happens first, so diff = in − 0. A `restart` arriving while it is not honoured is ignored.
- Reset mid-block: index, z, pending ZRLs, ena_out and all predictors go to 0; done=1. The partial block is discarded.

## Timing
- Reset values:
  - ena_out=0, rdy_out=1, done=1.
  - out, size, run, dc, out_comp all 0.
- Single output register. A symbol appears with ena_out=1 in the cycle after the input transfer that generates it.
- rdy_out = (!ena_out || rdy_in) && no pending ZRL/EOB/held coefficient. This holds for zero coefficients too, for uniformity.
- Nonzero AC with z zeros accepted at cycle t:
  - ZRLs appear at t+1 .. t+floor(z/16).
  - The coefficient symbol appears at t+1+floor(z/16), assuming rdy_in=1.
  - rdy_out stays low until that last symbol is being consumed.
- While ena_out=1 && rdy_in=0, out/size/run/dc/out_comp hold stable.
- Throughput: 1 coefficient/cycle when no ZRLs occur and rdy_in=1.

## Configuration
- RUN_ENCODER_DC_PRED_EN defined:
  - Predictors are implemented.
  - DC symbol encodes in − pred[comp].
  - `restart` is functional.
- RUN_ENCODER_DC_PRED_EN undefined:
  - No predictor registers exist.
  - The DC symbol encodes the raw `in`, sign-extended to COEF_W+1.
  - `restart` is ignored.
  - `out_comp` still tracks `comp`.

## Test plan
- NUM_COMP=1, COEF_W=11, block {0,2,-2,-10,-11,-1,1,1,6,3,0,1,3,-1,0,0,0,0,-1,-1,0,0,1,1,0×25,1,0×14} → DC (size 0), then:
  - (0,2,002) (0,2,FFD) (0,4,FF5) (0,4,FF4) (0,1,FFE) (0,1,001) (0,1,001)
  - (0,3,006) (0,2,003) (1,1,001) (0,2,003) (0,1,FFE) (4,1,FFE) (0,1,FFE)
  - (2,1,001) (0,1,001) (15,0) (9,1,001) EOB; then done=1.
- DC prediction, DC-only blocks comp0=50, comp1=−20, comp0=45 → DC symbols (size 6, 032), (size 5, FEB), (size 3, FFA).
- Index 1..62 zero, index 63 = 5 → DC, three ZRLs, (14,3,005), no EOB; rdy_out low for 3 cycles.
- Backpressure: rdy_in=0 for 5 cycles during the ZRL burst → outputs stable, no symbol lost or duplicated, rdy_out=0 throughout.
- restart pulse between blocks, then comp0 DC=45 after prior 50 → diff 45 (size 6, 02D); restart mid-block ignored.
- rst asserted at index 30 → next cycle done=1, ena_out=0; a following block encodes with predictors at 0.
